cache_bus_arbiter: RTL

Arbitrates the single line-granular memory bus between the instruction cache and the data cache. Each cache issues whole-line burst reads (fills) or burst writes (writebacks). The arbiter grants one cache at a time with round-robin fairness, forwards the address and data handshakes to the granted cache only, and counts beats so it can signal line completion with `burst`. It sits between both cache controllers and the memory/AXI bridge.

---
 rtl/cache_bus_arbiter_pkg.sv | 19 +
 rtl/cache_bus_arbiter_if.sv | 40 ++++
 rtl/cache_bus_arbiter_rr_arb2.sv | 21 ++
 rtl/cache_bus_arbiter.sv | 119 +++++++++++
 4 files changed

// File: rtl/cache_bus_arbiter_pkg.sv
// Shared types and constants for the I-cache / D-cache memory bus arbiter.
package cache_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        LAST
    } state_t;

    localparam int unsigned LINE_WORDS = 16;
    localparam int unsigned CNT_W      = $clog2(LINE_WORDS);
    // Byte offset within a line: word index bits plus the two byte-lane bits.
    localparam int unsigned OFFSET_W   = CNT_W + 2;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/cache_bus_arbiter_if.sv
// Bundle of cache-side and memory-side bus signals; master is the arbiter's view.
interface cache_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              ic_sen,     dc_sen;
    logic              ic_wen,     dc_wen;
    logic [ADDR_W-1:0] ic_addr,    dc_addr;
    logic [DATA_W-1:0] ic_wdata,   dc_wdata;
    logic              ic_addr_ok, dc_addr_ok;
    logic              ic_data_ok, dc_data_ok;
    logic              ic_burst,   dc_burst;
    logic [DATA_W-1:0] ic_rdata,   dc_rdata;

    logic              m_req;
    logic              m_wen;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_addr_ok;
    logic              m_data_ok;
    logic [DATA_W-1:0] m_rdata;

    modport master (
        input  ic_sen, dc_sen, ic_wen, dc_wen, ic_addr, dc_addr, ic_wdata, dc_wdata,
        input  m_addr_ok, m_data_ok, m_rdata,
        output ic_addr_ok, dc_addr_ok, ic_data_ok, dc_data_ok, ic_burst, dc_burst,
        output ic_rdata, dc_rdata,
        output m_req, m_wen, m_addr, m_wdata
    );

    modport slave (
        output ic_sen, dc_sen, ic_wen, dc_wen, ic_addr, dc_addr, ic_wdata, dc_wdata,
        output m_addr_ok, m_data_ok, m_rdata,
        input  ic_addr_ok, dc_addr_ok, ic_data_ok, dc_data_ok, ic_burst, dc_burst,
        input  ic_rdata, dc_rdata,
        input  m_req, m_wen, m_addr, m_wdata
    );

endinterface

// File: rtl/cache_bus_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker; a tie goes to the requester that did not win last.
module rr_arb2
    import cache_bus_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid = req0 | req1;
        if (req0 && req1) begin
            winner = ~last;
        end else begin
            winner = req1 ? GNT_D : GNT_I;
        end
    end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Grants the line-burst memory bus to one cache at a time and counts beats to flag line completion.
module cache_bus_arbiter
    import cache_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic                 clk,
    input logic                 rst,
    cache_bus_arbiter_if.master bus
);

    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W - OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

    state_t            state, state_nx;
    logic              gnt;
    logic              last;
    logic              wen_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt;
    logic              pick_valid;
    logic              pick_winner;

    rr_arb2 u_rr_arb2 (
        .req0   (bus.ic_sen),
        .req1   (bus.dc_sen),
        .last   (last),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt    <= GNT_I;
            last   <= GNT_D;
            wen_q  <= 1'b0;
            addr_q <= '0;
            cnt    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt    <= pick_winner;
                        wen_q  <= (pick_winner == GNT_D) ? bus.dc_wen : bus.ic_wen;
                        addr_q <= (pick_winner == GNT_D) ? bus.dc_addr : bus.ic_addr;
                    end
                end
                ADDR: begin
                    if (bus.m_addr_ok) cnt <= '0;
                end
                DATA: begin
                    if (bus.m_data_ok) cnt <= cnt + 1'b1;
                end
                LAST: begin
                    last <= gnt;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (pick_valid) state_nx = ADDR;
            // A beat reported alongside the address acceptance is deliberately dropped.
            ADDR: if (bus.m_addr_ok) state_nx = DATA;
            DATA: if (bus.m_data_ok && (cnt == CNT_W'(LINE_WORDS - 1))) state_nx = LAST;
            LAST: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.m_req      = 1'b0;
        bus.m_wen      = 1'b0;
        bus.m_addr     = '0;
        bus.m_wdata    = '0;
        bus.ic_addr_ok = 1'b0;
        bus.dc_addr_ok = 1'b0;
        bus.ic_data_ok = 1'b0;
        bus.dc_data_ok = 1'b0;
        bus.ic_burst   = 1'b0;
        bus.dc_burst   = 1'b0;
        bus.ic_rdata   = bus.m_rdata;
        bus.dc_rdata   = bus.m_rdata;
        unique case (state)
            ADDR: begin
                bus.m_req      = 1'b1;
                bus.m_wen      = wen_q;
                bus.m_addr     = addr_q & LINE_MASK;
                bus.ic_addr_ok = bus.m_addr_ok & (gnt == GNT_I);
                bus.dc_addr_ok = bus.m_addr_ok & (gnt == GNT_D);
            end
            DATA: begin
                bus.m_req      = 1'b1;
                bus.m_wen      = wen_q;
                bus.m_addr     = addr_q & LINE_MASK;
                bus.m_wdata    = (gnt == GNT_D) ? bus.dc_wdata : bus.ic_wdata;
                bus.ic_data_ok = bus.m_data_ok & (gnt == GNT_I);
                bus.dc_data_ok = bus.m_data_ok & (gnt == GNT_D);
            end
            LAST: begin
                bus.ic_burst = (gnt == GNT_I);
                bus.dc_burst = (gnt == GNT_D);
            end
            default: ;
        endcase
    end

endmodule
